// File: rtl/pcileech_tlp_axis_to_tlp128.sv
// pcileech_tlp_axis_to_tlp128
// Collects a TLP arriving as 64-bit AXI-stream beats into a flat buffer of
// 66-bit dual-dword slots and presents it as one wide word to a consumer
// that pulls it with a request strobe. TLPs longer than the buffer are
// swallowed whole and counted.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   tlp_rx_data/keep    beat payload (DW1 in [31:0], DW2 in [63:32]) and byte enables
//   tlp_rx_last/valid   end-of-TLP marker and beat valid
//   tlp_rx_ready        beat accept (registered, low while a TLP is held)
//   tlp_out_data        MAX_DDW slots of {KEEP DW2, LAST, DW2, DW1}
//   tlp_out_valid       one-cycle strobe, tlp_out_data is the complete TLP
//   tlp_out_has_data    a complete TLP is held waiting for tlp_out_req_data
//   tlp_out_req_data    consumer pull request
//   drop_count          saturating count of oversize TLPs discarded
//
// state   | meaning
// COLLECT | writing accepted beats into consecutive slots
// HOLD    | complete TLP held, input stalled, waiting for a request
// DROP    | buffer overflowed, discarding beats up to the TLP's last beat

module pcileech_tlp_axis_to_tlp128 #(
  parameter int MAX_DDW = 18,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          tlp_rx_data,
  input  logic [7:0]           tlp_rx_keep,
  input  logic                 tlp_rx_last,
  input  logic                 tlp_rx_valid,
  output logic                 tlp_rx_ready,
  output logic [66*MAX_DDW-1:0] tlp_out_data,
  output logic                 tlp_out_valid,
  output logic                 tlp_out_has_data,
  input  logic                 tlp_out_req_data,
  output logic [CNT_W-1:0]     drop_count
);

  typedef enum logic [1:0] {COLLECT, HOLD, DROP} state_t;

  localparam logic [4:0] LAST_IDX = 5'(MAX_DDW - 1);

  state_t      state, state_next;
  logic [65:0] slot [MAX_DDW];
  logic [4:0]  cnt;
  logic        accept;
  logic        at_end;
  logic        valid_next;
  logic        ready_next;
  logic        keep_dw2;
  logic        overflow;

  assign accept   = tlp_rx_valid & tlp_rx_ready;
  assign at_end   = (cnt == LAST_IDX);
  // keep[3:0] is implied; only the upper dword of a final beat can be empty.
  assign keep_dw2 = tlp_rx_last ? (|tlp_rx_keep[7:4]) : 1'b1;
  assign overflow = (state == COLLECT) && accept && !tlp_rx_last && at_end;

  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    case (state)
      COLLECT: begin
        if (accept) begin
          if (tlp_rx_last)  state_next = HOLD;
          else if (at_end)  state_next = DROP;
        end
      end
      HOLD: begin
        if (tlp_out_req_data) begin
          state_next = COLLECT;
          valid_next = 1'b1;
        end
      end
      DROP: begin
        if (accept && tlp_rx_last) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
    // Input stays stalled through the output strobe cycle so the buffer can
    // be cleared before the next TLP starts filling it.
    ready_next = (state_next != HOLD) && !valid_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= COLLECT;
      cnt              <= '0;
      tlp_rx_ready     <= 1'b0;
      tlp_out_valid    <= 1'b0;
      tlp_out_has_data <= 1'b0;
      drop_count       <= '0;
      for (int i = 0; i < MAX_DDW; i++) slot[i] <= '0;
    end else begin
      state         <= state_next;
      tlp_rx_ready  <= ready_next;
      tlp_out_valid <= valid_next;

      if (valid_next)
        tlp_out_has_data <= 1'b0;
      else if ((state == COLLECT) && accept && tlp_rx_last)
        tlp_out_has_data <= 1'b1;

      if ((state == DROP) && accept && tlp_rx_last && (drop_count != '1))
        drop_count <= drop_count + CNT_W'(1);

      // Unwritten slots must read zero so the first LAST=1 slot ends the TLP.
      if (tlp_out_valid || overflow) begin
        cnt <= '0;
        for (int i = 0; i < MAX_DDW; i++) slot[i] <= '0;
      end else if ((state == COLLECT) && accept) begin
        cnt <= cnt + 5'd1;
        for (int i = 0; i < MAX_DDW; i++)
          if (cnt == 5'(i)) slot[i] <= {keep_dw2, tlp_rx_last, tlp_rx_data};
      end
    end
  end

  for (genvar g = 0; g < MAX_DDW; g++) begin : g_out
    assign tlp_out_data[66*g +: 66] = slot[g];
  end

endmodule

// File: tb/tb_pcileech_tlp_axis_to_tlp128.sv
module tb_pcileech_tlp_axis_to_tlp128;
  localparam int MAX   = 18;
  localparam int CNT_W = 16;
  localparam int W     = 66 * MAX;

  logic             clk;
  logic             rst;
  logic [63:0]      tlp_rx_data;
  logic [7:0]       tlp_rx_keep;
  logic             tlp_rx_last;
  logic             tlp_rx_valid;
  logic             tlp_rx_ready;
  logic [W-1:0]     tlp_out_data;
  logic             tlp_out_valid;
  logic             tlp_out_has_data;
  logic             tlp_out_req_data;
  logic [CNT_W-1:0] drop_count;

  pcileech_tlp_axis_to_tlp128 #(.MAX_DDW(MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .tlp_rx_data(tlp_rx_data), .tlp_rx_keep(tlp_rx_keep),
    .tlp_rx_last(tlp_rx_last), .tlp_rx_valid(tlp_rx_valid),
    .tlp_rx_ready(tlp_rx_ready), .tlp_out_data(tlp_out_data),
    .tlp_out_valid(tlp_out_valid), .tlp_out_has_data(tlp_out_has_data),
    .tlp_out_req_data(tlp_out_req_data), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int i = 0; i < MAX; i++)
        if (act[66*i +: 66] !== exp[66*i +: 66]) begin
          $display("FAIL %s slot %0d actual=%h required=%h", name, i,
                   act[66*i +: 66], exp[66*i +: 66]);
          break;
        end
    end
  endtask

  // ---------------- reference model (TLP-level) ----------------
  logic [63:0]  cur_data [MAX];
  logic [7:0]   cur_keep [MAX];
  int           cur_n;
  logic [W-1:0] exp_q [$];
  int           e_drops;
  bit           e_has, e_valid, e_zero, prev_rst;
  logic [W-1:0] last_out;
  int           valid_pulses = 0;

  // Expected packed word for a TLP of n beats (n <= MAX).
  function automatic logic [W-1:0] pack_cur(input int n);
    logic [W-1:0] v;
    logic [65:0]  s;
    v = '0;
    for (int i = 0; i < n; i++) begin
      s = {(i == n - 1) ? (|cur_keep[i][7:4]) : 1'b1, (i == n - 1), cur_data[i]};
      v[66*i +: 66] = s;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    bit nv, done;
    if (rst) begin
      chk("rst_ready", 32'(tlp_rx_ready), 0);
      chk("rst_has", 32'(tlp_out_has_data), 0);
      chk("rst_valid", 32'(tlp_out_valid), 0);
      chk("rst_drop", 32'(drop_count), 0);
      chk_vec("rst_data", tlp_out_data, '0);
      e_has = 0; e_valid = 0; e_zero = 0; e_drops = 0; cur_n = 0;
      exp_q.delete();
      prev_rst = 1;
    end else begin
      chk("valid", 32'(tlp_out_valid), 32'(e_valid));
      chk("has_data", 32'(tlp_out_has_data), 32'(e_has));
      chk("drop_count", 32'(drop_count), 32'(e_drops));
      if (e_has || e_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL out_data no TLP expected but has_data/valid seen");
        end else chk_vec("out_data", tlp_out_data, exp_q[0]);
      end
      if (e_valid) begin
        last_out = tlp_out_data;
        valid_pulses++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (e_zero) chk_vec("cleared_after_valid", tlp_out_data, '0);
      if (e_has) chk("ready_in_hold", 32'(tlp_rx_ready), 0);
      else if (!e_valid && !prev_rst) chk("ready_idle", 32'(tlp_rx_ready), 1);

      // advance model by the coming edge
      e_zero = e_valid;
      nv = e_has && tlp_out_req_data;
      done = 0;
      if (tlp_rx_valid && tlp_rx_ready) begin
        if (cur_n < MAX) begin
          cur_data[cur_n] = tlp_rx_data;
          cur_keep[cur_n] = tlp_rx_keep;
        end
        cur_n++;
        if (tlp_rx_last) begin
          if (cur_n <= MAX) begin
            exp_q.push_back(pack_cur(cur_n));
            done = 1;
          end else if (e_drops < (1 << CNT_W) - 1) e_drops++;
          cur_n = 0;
        end
      end
      e_has   = nv ? 1'b0 : (e_has || done);
      e_valid = nv;
      prev_rst = 0;
    end
  end

  // ---------------- consumer ----------------
  int req_mode = 2;  // 0 random, 1 always, 2 off, 3 one pulse
  initial begin
    tlp_out_req_data = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (req_mode)
        0: tlp_out_req_data = ($urandom_range(0, 2) == 0);
        1: tlp_out_req_data = 1'b1;
        3: begin tlp_out_req_data = 1'b1; req_mode = 2; end
        default: tlp_out_req_data = 1'b0;
      endcase
    end
  end

  // ---------------- driver ----------------
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input bit l, input int gap);
    bit r, done;
    int budget;
    tlp_rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    tlp_rx_valid = 1'b1; tlp_rx_data = d; tlp_rx_keep = k; tlp_rx_last = l;
    done = 0; budget = 300;
    while (!done && budget > 0) begin
      @(negedge clk); r = tlp_rx_ready;
      @(posedge clk); #1;
      if (r) done = 1;
      budget--;
    end
    tlp_rx_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL beat_accept_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic wait_pulses(input int target);
    int budget = 400;
    while (valid_pulses < target && budget > 0) begin @(posedge clk); #1; budget--; end
    if (valid_pulses < target) begin
      total++; bad++;
      $display("FAIL valid_pulse_timeout actual=%0d required=%0d", valid_pulses, target);
    end
  endtask

  initial begin
    int base, n;
    logic [63:0] d;
    rst = 1'b1; tlp_rx_valid = 0; tlp_rx_data = '0; tlp_rx_keep = '0; tlp_rx_last = 0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(tlp_rx_ready), 1);

    // 3DW MRd
    req_mode = 2;
    send_beat(64'h0000000F_00000001, 8'hFF, 0, 0);
    send_beat(64'h00000000_12345678, 8'h0F, 1, 0);
    chk("mrd_has_data", 32'(tlp_out_has_data), 1);
    base = valid_pulses;
    req_mode = 1;
    wait_pulses(base + 1);
    req_mode = 2;
    chk_vec("mrd_slot0", {{(W-66){1'b0}}, last_out[65:0]}, {{(W-66){1'b0}}, 66'h2_0000000F_00000001});
    chk_vec("mrd_slot1", {{(W-66){1'b0}}, last_out[131:66]}, {{(W-66){1'b0}}, 66'h1_00000000_12345678});
    chk_vec("mrd_slots_rest", {last_out[W-1:132], 132'h0}, '0);

    // 18-beat TLP fills the buffer exactly
    for (int i = 0; i < MAX; i++)
      send_beat({32'(i * 3 + 1), 32'(i)}, 8'hFF, (i == MAX - 1), 0);
    base = valid_pulses;
    req_mode = 1;
    wait_pulses(base + 1);
    req_mode = 2;
    chk("max_slot17_flags", 32'(last_out[66*17+64 +: 2]), 3);
    chk("max_slot17_dw1", last_out[66*17 +: 32], 17);
    chk("max_no_drop", 32'(drop_count), 0);

    // 19-beat TLP is dropped
    for (int i = 0; i < MAX + 1; i++) begin
      send_beat({$urandom, $urandom}, 8'hFF, (i == MAX), $urandom_range(0, 1));
      if (i == MAX - 1) chk("drop_ready_stays", 32'(tlp_rx_ready), 1);
    end
    chk("drop_count_one", 32'(drop_count), 1);
    send_beat(64'hAAAA0000_BBBB0001, 8'hFF, 0, 0);
    send_beat(64'hCCCC0002_DDDD0003, 8'hF0, 1, 0);
    base = valid_pulses;
    req_mode = 1;
    wait_pulses(base + 1);
    req_mode = 2;
    chk("after_drop_dw1", last_out[31:0], 32'hBBBB0001);

    // hold with backpressure
    send_beat(64'h1, 8'hFF, 0, 0);
    send_beat(64'h2, 8'hFF, 1, 0);
    base = valid_pulses;
    fork
      send_beat(64'h55556666_77778888, 8'hFF, 1, 0);
      begin
        repeat (10) begin
          @(posedge clk); #1;
          chk("hold_ready_low", 32'(tlp_rx_ready), 0);
        end
        req_mode = 3;
      end
    join
    wait_pulses(base + 1);
    chk("bp_one_pulse", 32'(valid_pulses), 32'(base + 1));
    req_mode = 1;
    wait_pulses(base + 2);
    chk("bp_held_beat", last_out[63:0], 64'h55556666_77778888);

    // continuous request while idle
    repeat (5) begin @(posedge clk); #1; end
    base = valid_pulses;
    send_beat(64'h9, 8'hFF, 0, 0);
    send_beat(64'hA, 8'hFF, 1, 0);
    @(posedge clk); #1;
    chk("req_cont_valid_timing", 32'(tlp_out_valid), 1);
    repeat (10) begin @(posedge clk); #1; end
    chk("req_cont_single_pulse", 32'(valid_pulses), 32'(base + 1));
    req_mode = 2;

    // reset mid-TLP
    send_beat(64'hDEAD_BEEF, 8'hFF, 0, 0);
    base = valid_pulses;
    rst = 1'b1; #1;
    chk("midrst_ready", 32'(tlp_rx_ready), 0);
    chk("midrst_has", 32'(tlp_out_has_data), 0);
    chk("midrst_drop", 32'(drop_count), 0);
    chk_vec("midrst_data", tlp_out_data, '0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_no_pulse", 32'(valid_pulses), 32'(base));
    send_beat(64'h0000_0123_0000_0456, 8'hFF, 0, 0);
    send_beat(64'h0000_0789, 8'h0F, 1, 0);
    req_mode = 0;
    wait_pulses(base + 1);
    chk("midrst_slot0", last_out[31:0], 32'h456);

    // randomized traffic
    req_mode = 0;
    for (int t = 0; t < 60; t++) begin
      n = $urandom_range(1, MAX + 3);
      for (int i = 0; i < n; i++) begin
        d = {$urandom, $urandom};
        send_beat(d, 8'($urandom), (i == n - 1), $urandom_range(0, 2));
      end
    end

    req_mode = 1;
    n = 0;
    while (tlp_out_has_data && n < 200) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    chk("drain_has_data", 32'(tlp_out_has_data), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcileech_tlp_axis_to_tlp128.md
PCILEECH_TLP_AXIS_TO_TLP128 -- requirements
Module: pcileech_tlp_axis_to_tlp128

Interface
REQ-001 SHALL have parameter MAX_DDW, default 18, giving the number of 66-bit dual-dword slots in the output buffer.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the drop counter.
REQ-003 clk  input  1  single clock; all state SHALL be sampled on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tlp_rx_data  input  64  AXI-stream beat, with DW1 in [31:0] and DW2 in [63:32].
REQ-006 tlp_rx_keep  input  8  byte enables per beat.
REQ-007 tlp_rx_last  input  1  marks the final beat of a TLP.
REQ-008 tlp_rx_valid  input  1  beat valid.
REQ-009 tlp_rx_ready  output  1  beat accepted when valid and ready are both high.
REQ-010 tlp_out_data  output  66*MAX_DDW  packed TLP; slot i occupies [66*i+65:66*i], holding [31:0] DW1, [63:32] DW2, [64] LAST, [65] KEEP DW2.
REQ-011 tlp_out_valid  output  1  one-cycle strobe marking tlp_out_data as a complete TLP.
REQ-012 tlp_out_has_data  output  1  a complete TLP is held and awaiting request.
REQ-013 tlp_out_req_data  input  1  request from the downstream consumer.
REQ-014 drop_count  output  CNT_W  saturating count of oversize TLPs discarded.

Function
REQ-015 SHALL implement a three-state FSM: COLLECT, HOLD, DROP.
REQ-016 tlp_rx_ready SHALL be 1 in COLLECT and DROP, and 0 in HOLD.
REQ-017 COLLECT: each accepted beat SHALL be written to slot[cnt], and cnt SHALL increment; cnt is a 5-bit slot index.
REQ-018 Slot write: DW1 = data[31:0]; DW2 = data[63:32]; LAST = tlp_rx_last; KEEP = 1 when not last, otherwise (keep[7:4] != 0).
REQ-019 keep[3:0] SHALL be treated as all-ones; the value present is ignored.
REQ-020 An accepted beat with tlp_rx_last = 1 in COLLECT SHALL move the FSM to HOLD on the next edge, with has_data = 1 from that edge.
REQ-021 An accepted non-last beat at cnt == MAX_DDW-1 SHALL move the FSM to DROP, clear the buffer to zero, and reset cnt to 0.
REQ-022 DROP: accepted beats SHALL be discarded; an accepted last beat SHALL return the FSM to COLLECT and increment drop_count, saturating at all-ones.
REQ-023 HOLD: when req_data = 1 is sampled, the next cycle SHALL have tlp_out_valid = 1 for exactly one cycle and has_data = 0, and the FSM SHALL return to COLLECT.
REQ-024 During that tlp_out_valid cycle, tlp_out_data SHALL carry the held TLP unchanged.
REQ-025 On the cycle after tlp_out_valid, all slots and cnt SHALL be zero.
REQ-026 The beat-to-valid latency SHALL be: last beat accepted at edge N, has_data at N+1, req sampled at edge M >= N+1, tlp_out_valid high at M+1.
REQ-027 req_data while has_data = 0 SHALL have no effect and SHALL NOT latch as a pending request.
REQ-028 Unwritten slots SHALL read all-zero, including LAST = 0, so the first slot with LAST = 1 terminates the TLP.
REQ-029 tlp_rx_valid = 0 SHALL leave the state unchanged.
REQ-030 tlp_out_data SHALL be driven directly from registers, with no combinational path from tlp_rx_* to tlp_out_*.
REQ-031 tlp_rx_ready SHALL be a registered function of the state only.

Reset
REQ-032 While rst = 1: state = COLLECT; cnt = 0; all slots = 0; tlp_out_valid = 0; tlp_out_has_data = 0; drop_count = 0.
REQ-033 While rst = 1, tlp_rx_ready SHALL be 0; it SHALL become 1 on the first clk edge after rst deasserts.
REQ-034 Reset asserted mid-TLP or in HOLD SHALL discard the partial or held TLP, with no tlp_out_valid pulse.

Verification
REQ-035 3DW MRd, beat0 = 0x0000000F_00000001 (not last) and beat1 = 0x_xxxx_12345678 with keep = 0x0F and last:
- has_data rises 1 cycle after beat1.
- slot0 = {KEEP 1, LAST 0, DW2 0x0000000F, DW1 0x00000001}; slot1 = {KEEP 0, LAST 1, DW1 0x12345678}.
- slots 2..17 = 0.
REQ-036 18-beat TLP (4 header DW + 32 data DW), last on beat 17 with keep = 0xFF: slot17 = {KEEP 1, LAST 1}, no drop, drop_count = 0.
REQ-037 19-beat TLP with no last until beat 18:
- FSM enters DROP after beat 17; ready stays 1.
- After beat 18, drop_count = 1, has_data never asserts, and the next 2-beat TLP is captured correctly.
REQ-038 Hold and backpressure:
- After a complete TLP, ready = 0.
- Source holds valid = 1 for 10 cycles; no beats are lost.
- req_data pulses: tlp_out_valid pulses once, then the held beat is accepted the cycle after ready returns.
REQ-039 req_data = 1 continuously while idle, then a 2-beat TLP arrives: exactly one tlp_out_valid pulse, 2 cycles after the last beat.
REQ-040 rst pulsed after beat 1 of 3 (no last yet): all outputs at their reset values, no tlp_out_valid, and a subsequent TLP captured starting at slot0.
